// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared state, ALU, mux-select and instruction-field encodings
package ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH0, FETCH1, DECODE, INDIR, EXEC1, EXEC2, EXEC3, INT0, INT1, INT2, HALT
    } state_t;

    localparam logic [3:0] ALU_NOP  = 4'd0;
    localparam logic [3:0] ALU_AND  = 4'd1;
    localparam logic [3:0] ALU_ADD  = 4'd2;
    localparam logic [3:0] ALU_LOAD = 4'd3;
    localparam logic [3:0] ALU_CLA  = 4'd4;
    localparam logic [3:0] ALU_CLE  = 4'd5;
    localparam logic [3:0] ALU_CMA  = 4'd6;
    localparam logic [3:0] ALU_CME  = 4'd7;
    localparam logic [3:0] ALU_CIR  = 4'd8;
    localparam logic [3:0] ALU_CIL  = 4'd9;
    localparam logic [3:0] ALU_INC  = 4'd10;
    localparam logic [3:0] ALU_INPR = 4'd11;

    localparam logic [1:0] AR_SEL_PC   = 2'd0;
    localparam logic [1:0] AR_SEL_IR   = 2'd1;
    localparam logic [1:0] AR_SEL_MEM  = 2'd2;
    localparam logic [1:0] AR_SEL_ZERO = 2'd3;

    localparam logic [1:0] WSEL_AC = 2'd0;
    localparam logic [1:0] WSEL_DR = 2'd1;
    localparam logic [1:0] WSEL_PC = 2'd2;

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_LDA = 3'd2;
    localparam logic [2:0] OP_STA = 3'd3;
    localparam logic [2:0] OP_BUN = 3'd4;
    localparam logic [2:0] OP_BSA = 3'd5;
    localparam logic [2:0] OP_ISZ = 3'd6;
    localparam logic [2:0] OP_RIO = 3'd7;

    // Bit positions within ir[11:0]; higher position wins when several are set
    localparam logic [3:0] RR_CLA = 4'd11;
    localparam logic [3:0] RR_CLE = 4'd10;
    localparam logic [3:0] RR_CMA = 4'd9;
    localparam logic [3:0] RR_CME = 4'd8;
    localparam logic [3:0] RR_CIR = 4'd7;
    localparam logic [3:0] RR_CIL = 4'd6;
    localparam logic [3:0] RR_INC = 4'd5;
    localparam logic [3:0] RR_SPA = 4'd4;
    localparam logic [3:0] RR_SNA = 4'd3;
    localparam logic [3:0] RR_SZA = 4'd2;
    localparam logic [3:0] RR_SZE = 4'd1;
    localparam logic [3:0] RR_HLT = 4'd0;

    localparam logic [3:0] IO_INP = 4'd11;
    localparam logic [3:0] IO_OUT = 4'd10;
    localparam logic [3:0] IO_SKI = 4'd9;
    localparam logic [3:0] IO_SKO = 4'd8;
    localparam logic [3:0] IO_ION = 4'd7;
    localparam logic [3:0] IO_IOF = 4'd6;

    typedef struct packed {
        logic       ac_ld;
        logic [3:0] alu_op;
        logic       skip;
        logic       hlt;
        logic       out_ld;
        logic       fgi_clr;
        logic       fgo_clr;
        logic       ion;
        logic       iof;
    } rr_ctl_t;

endpackage

// File: rtl/control_sequencer_if.sv
// rtl/control_sequencer_if.sv - status inputs and control strobes between sequencer and datapath
interface control_sequencer_if #(
    parameter int DATA_W = 16
);
    logic              run;
    logic [DATA_W-1:0] ir;
    logic              ac_zero;
    logic              ac_sign;
    logic              e_flag;
    logic              dr_zero;
    logic              fgi;
    logic              fgo;

    logic              ar_ld;
    logic [1:0]        ar_sel;
    logic              pc_ld;
    logic              pc_inc;
    logic              pc_clr;
    logic              ir_ld;
    logic              dr_ld;
    logic              dr_inc;
    logic              ac_ld;
    logic [3:0]        alu_op;
    logic              mem_rd;
    logic              mem_wr;
    logic [1:0]        mem_wsel;
    logic              out_ld;
    logic              fgi_clr;
    logic              fgo_clr;
    logic              ien;
    logic              halted;

    modport master (
        input  run, ir, ac_zero, ac_sign, e_flag, dr_zero, fgi, fgo,
        output ar_ld, ar_sel, pc_ld, pc_inc, pc_clr, ir_ld, dr_ld, dr_inc,
               ac_ld, alu_op, mem_rd, mem_wr, mem_wsel, out_ld, fgi_clr, fgo_clr,
               ien, halted
    );

    modport slave (
        output run, ir, ac_zero, ac_sign, e_flag, dr_zero, fgi, fgo,
        input  ar_ld, ar_sel, pc_ld, pc_inc, pc_clr, ir_ld, dr_ld, dr_inc,
               ac_ld, alu_op, mem_rd, mem_wr, mem_wsel, out_ld, fgi_clr, fgo_clr,
               ien, halted
    );
endinterface

// File: rtl/ctrl_rr_decode.sv
// rtl/ctrl_rr_decode.sv - highest-set-bit decode of register-reference and I/O instructions
module ctrl_rr_decode
    import ctrl_pkg::*;
(
    input  logic [11:0] i_bits,
    input  logic        i_io,
    input  logic        i_ac_zero,
    input  logic        i_ac_sign,
    input  logic        i_e_flag,
    input  logic        i_fgi,
    input  logic        i_fgo,
    output rr_ctl_t     o_ctl
);
    logic [11:0] w_bits;
    logic [3:0]  w_top;
    logic        w_any;

    always_comb begin
        // I/O instructions only define ir[11:6]; lower bits never select an action
        w_bits = i_io ? {i_bits[11:6], 6'b0} : i_bits;
        w_top  = 4'd0;
        w_any  = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (w_bits[k]) begin
                w_top = k[3:0];
                w_any = 1'b1;
            end
        end

        o_ctl = '0;
        if (w_any && !i_io) begin
            case (w_top)
                RR_CLA:  begin o_ctl.ac_ld = 1'b1; o_ctl.alu_op = ALU_CLA; end
                RR_CLE:  begin o_ctl.ac_ld = 1'b1; o_ctl.alu_op = ALU_CLE; end
                RR_CMA:  begin o_ctl.ac_ld = 1'b1; o_ctl.alu_op = ALU_CMA; end
                RR_CME:  begin o_ctl.ac_ld = 1'b1; o_ctl.alu_op = ALU_CME; end
                RR_CIR:  begin o_ctl.ac_ld = 1'b1; o_ctl.alu_op = ALU_CIR; end
                RR_CIL:  begin o_ctl.ac_ld = 1'b1; o_ctl.alu_op = ALU_CIL; end
                RR_INC:  begin o_ctl.ac_ld = 1'b1; o_ctl.alu_op = ALU_INC; end
                RR_SPA:  o_ctl.skip = ~i_ac_sign;
                RR_SNA:  o_ctl.skip = i_ac_sign;
                RR_SZA:  o_ctl.skip = i_ac_zero;
                RR_SZE:  o_ctl.skip = ~i_e_flag;
                default: o_ctl.hlt  = 1'b1;
            endcase
        end else if (w_any) begin
            case (w_top)
                IO_INP: begin
                    o_ctl.ac_ld   = 1'b1;
                    o_ctl.alu_op  = ALU_INPR;
                    o_ctl.fgi_clr = 1'b1;
                end
                IO_OUT: begin
                    o_ctl.out_ld  = 1'b1;
                    o_ctl.fgo_clr = 1'b1;
                end
                IO_SKI:  o_ctl.skip = i_fgi;
                IO_SKO:  o_ctl.skip = i_fgo;
                IO_ION:  o_ctl.ion  = 1'b1;
                default: o_ctl.iof  = 1'b1;
            endcase
        end
    end
endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - fetch/decode/execute/interrupt control FSM with Moore strobe decode
module control_sequencer
    import ctrl_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12
) (
    input  logic                clk,
    input  logic                rst_n,
    control_sequencer_if.master bus
);
    state_t     r_state;
    logic       r_ien;

    logic [2:0] w_opc;
    logic       w_ibit;
    rr_ctl_t    w_rr;
    logic       w_rio_exec;
    logic       w_ien_nxt;
    state_t     w_done_state;

    logic       w_ar_ld, w_pc_ld, w_pc_inc, w_pc_clr, w_ir_ld, w_dr_ld, w_dr_inc;
    logic       w_ac_ld, w_mem_rd, w_mem_wr, w_out_ld, w_fgi_clr, w_fgo_clr;
    logic [1:0] w_ar_sel, w_mem_wsel;
    logic [3:0] w_alu_op;

    assign w_opc  = bus.ir[ADDR_W+2:ADDR_W];
    assign w_ibit = bus.ir[DATA_W-1];

    ctrl_rr_decode u_rr_decode (
        .i_bits    (bus.ir[11:0]),
        .i_io      (w_ibit),
        .i_ac_zero (bus.ac_zero),
        .i_ac_sign (bus.ac_sign),
        .i_e_flag  (bus.e_flag),
        .i_fgi     (bus.fgi),
        .i_fgo     (bus.fgo),
        .o_ctl     (w_rr)
    );

    // ION/IOF take effect before the interrupt test so ION with a pending flag traps at once
    assign w_rio_exec   = (r_state == EXEC1) && (w_opc == OP_RIO);
    assign w_ien_nxt    = (w_rio_exec && w_rr.ion) ? 1'b1 :
                          (w_rio_exec && w_rr.iof) ? 1'b0 : r_ien;
    assign w_done_state = (w_ien_nxt && (bus.fgi || bus.fgo)) ? INT0 : FETCH0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FETCH0;
            r_ien   <= 1'b0;
        end else begin
            r_ien <= w_ien_nxt;
            case (r_state)
                FETCH0: r_state <= FETCH1;
                FETCH1: r_state <= DECODE;
                DECODE: r_state <= (w_ibit && w_opc != OP_RIO) ? INDIR : EXEC1;
                INDIR:  r_state <= EXEC1;
                EXEC1: begin
                    case (w_opc)
                        OP_AND, OP_ADD, OP_LDA, OP_BSA, OP_ISZ: r_state <= EXEC2;
                        OP_RIO:  r_state <= w_rr.hlt ? HALT : w_done_state;
                        default: r_state <= w_done_state;
                    endcase
                end
                EXEC2:  r_state <= (w_opc == OP_ISZ) ? EXEC3 : w_done_state;
                EXEC3:  r_state <= w_done_state;
                INT0:   r_state <= INT1;
                INT1:   r_state <= INT2;
                INT2: begin
                    r_state <= FETCH0;
                    r_ien   <= 1'b0;
                end
                HALT:    if (bus.run) r_state <= FETCH0;
                default: r_state <= FETCH0;
            endcase
        end
    end

    always_comb begin
        w_ar_ld    = 1'b0;
        w_ar_sel   = AR_SEL_PC;
        w_pc_ld    = 1'b0;
        w_pc_inc   = 1'b0;
        w_pc_clr   = 1'b0;
        w_ir_ld    = 1'b0;
        w_dr_ld    = 1'b0;
        w_dr_inc   = 1'b0;
        w_ac_ld    = 1'b0;
        w_alu_op   = ALU_NOP;
        w_mem_rd   = 1'b0;
        w_mem_wr   = 1'b0;
        w_mem_wsel = WSEL_AC;
        w_out_ld   = 1'b0;
        w_fgi_clr  = 1'b0;
        w_fgo_clr  = 1'b0;
        case (r_state)
            FETCH0: w_ar_ld = 1'b1;
            FETCH1: begin
                w_mem_rd = 1'b1;
                w_ir_ld  = 1'b1;
                w_pc_inc = 1'b1;
            end
            DECODE: begin
                w_ar_ld  = 1'b1;
                w_ar_sel = AR_SEL_IR;
            end
            INDIR: begin
                w_mem_rd = 1'b1;
                w_ar_ld  = 1'b1;
                w_ar_sel = AR_SEL_MEM;
            end
            EXEC1: begin
                case (w_opc)
                    OP_AND, OP_ADD, OP_LDA, OP_ISZ: begin
                        w_mem_rd = 1'b1;
                        w_dr_ld  = 1'b1;
                    end
                    OP_STA: w_mem_wr = 1'b1;
                    OP_BUN: w_pc_ld  = 1'b1;
                    OP_BSA: begin
                        w_mem_wr   = 1'b1;
                        w_mem_wsel = WSEL_PC;
                        w_pc_ld    = 1'b1;
                    end
                    default: begin
                        w_ac_ld   = w_rr.ac_ld;
                        w_alu_op  = w_rr.alu_op;
                        w_pc_inc  = w_rr.skip;
                        w_out_ld  = w_rr.out_ld;
                        w_fgi_clr = w_rr.fgi_clr;
                        w_fgo_clr = w_rr.fgo_clr;
                    end
                endcase
            end
            EXEC2: begin
                case (w_opc)
                    OP_AND:  begin w_ac_ld = 1'b1; w_alu_op = ALU_AND;  end
                    OP_ADD:  begin w_ac_ld = 1'b1; w_alu_op = ALU_ADD;  end
                    OP_LDA:  begin w_ac_ld = 1'b1; w_alu_op = ALU_LOAD; end
                    OP_BSA:  w_pc_inc = 1'b1;
                    OP_ISZ:  w_dr_inc = 1'b1;
                    default: w_pc_inc = 1'b0;
                endcase
            end
            EXEC3: begin
                w_mem_wr   = 1'b1;
                w_mem_wsel = WSEL_DR;
                w_pc_inc   = bus.dr_zero;
            end
            INT0: begin
                w_ar_ld  = 1'b1;
                w_ar_sel = AR_SEL_ZERO;
            end
            INT1: begin
                w_mem_wr   = 1'b1;
                w_mem_wsel = WSEL_PC;
                w_pc_clr   = 1'b1;
            end
            INT2:    w_pc_inc = 1'b1;
            default: w_ar_ld  = 1'b0;
        endcase
    end

    // Strobes are forced low while reset is held, independent of the clock
    assign bus.ar_ld    = rst_n & w_ar_ld;
    assign bus.ar_sel   = rst_n ? w_ar_sel : 2'd0;
    assign bus.pc_ld    = rst_n & w_pc_ld;
    assign bus.pc_inc   = rst_n & w_pc_inc;
    assign bus.pc_clr   = rst_n & w_pc_clr;
    assign bus.ir_ld    = rst_n & w_ir_ld;
    assign bus.dr_ld    = rst_n & w_dr_ld;
    assign bus.dr_inc   = rst_n & w_dr_inc;
    assign bus.ac_ld    = rst_n & w_ac_ld;
    assign bus.alu_op   = rst_n ? w_alu_op : 4'd0;
    assign bus.mem_rd   = rst_n & w_mem_rd;
    assign bus.mem_wr   = rst_n & w_mem_wr;
    assign bus.mem_wsel = rst_n ? w_mem_wsel : 2'd0;
    assign bus.out_ld   = rst_n & w_out_ld;
    assign bus.fgi_clr  = rst_n & w_fgi_clr;
    assign bus.fgo_clr  = rst_n & w_fgo_clr;
    assign bus.ien      = rst_n & r_ien;
    assign bus.halted   = rst_n & (r_state == HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - directed self-checking bench for control_sequencer
module tb_control_sequencer;
    import ctrl_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    control_sequencer_if #(.DATA_W(16)) bus ();

    control_sequencer #(.DATA_W(16), .ADDR_W(12)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // {ar_ld, ar_sel, pc_ld, pc_inc, pc_clr, ir_ld, dr_ld, dr_inc, ac_ld, alu_op,
    //  mem_rd, mem_wr, mem_wsel, out_ld, fgi_clr, fgo_clr}
    logic [20:0] w_obs;
    assign w_obs = {bus.ar_ld, bus.ar_sel, bus.pc_ld, bus.pc_inc, bus.pc_clr, bus.ir_ld,
                    bus.dr_ld, bus.dr_inc, bus.ac_ld, bus.alu_op, bus.mem_rd, bus.mem_wr,
                    bus.mem_wsel, bus.out_ld, bus.fgi_clr, bus.fgo_clr};

    localparam logic [20:0] B_NONE     = 21'd0;
    localparam logic [20:0] B_AR_LD    = 21'd1 << 20;
    localparam logic [20:0] B_SEL_IR   = 21'd1 << 18;
    localparam logic [20:0] B_SEL_MEM  = 21'd2 << 18;
    localparam logic [20:0] B_SEL_ZERO = 21'd3 << 18;
    localparam logic [20:0] B_PC_LD    = 21'd1 << 17;
    localparam logic [20:0] B_PC_INC   = 21'd1 << 16;
    localparam logic [20:0] B_PC_CLR   = 21'd1 << 15;
    localparam logic [20:0] B_IR_LD    = 21'd1 << 14;
    localparam logic [20:0] B_DR_LD    = 21'd1 << 13;
    localparam logic [20:0] B_DR_INC   = 21'd1 << 12;
    localparam logic [20:0] B_AC_LD    = 21'd1 << 11;
    localparam logic [20:0] B_MEM_RD   = 21'd1 << 6;
    localparam logic [20:0] B_MEM_WR   = 21'd1 << 5;
    localparam logic [20:0] B_WSEL_DR  = 21'd1 << 3;
    localparam logic [20:0] B_WSEL_PC  = 21'd2 << 3;
    localparam logic [20:0] B_OUT_LD   = 21'd1 << 2;
    localparam logic [20:0] B_FGI_CLR  = 21'd1 << 1;
    localparam logic [20:0] B_FGO_CLR  = 21'd1;

    int n_pass  = 0;
    int n_total = 0;

    function automatic logic [20:0] alu(input logic [3:0] op);
        return B_AC_LD | ({17'd0, op} << 7);
    endfunction

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.run = 1'b0; bus.ir = 16'h0000; bus.ac_zero = 1'b0; bus.ac_sign = 1'b0;
        bus.e_flag = 1'b0; bus.dr_zero = 1'b0; bus.fgi = 1'b0; bus.fgo = 1'b0;
        rst_n = 1'b0;
        repeat (2) cyc();
        n_total++;
        if (w_obs !== B_NONE) $display("FAIL reset_strobes obs=%h exp=%h", w_obs, B_NONE);
        else n_pass++;
        n_total++;
        if (bus.ien !== 1'b0 || bus.halted !== 1'b0)
            $display("FAIL reset_flags ien=%b halted=%b exp=0/0", bus.ien, bus.halted);
        else n_pass++;
        rst_n = 1'b1;
        #1;
        n_total++;
        if (w_obs !== B_AR_LD) $display("FAIL reset_fetch0 obs=%h exp=%h", w_obs, B_AR_LD);
        else n_pass++;
    endtask

    task automatic test_lda();
        logic [20:0] exp [6];
        exp = '{B_AR_LD, B_MEM_RD | B_IR_LD | B_PC_INC, B_AR_LD | B_SEL_IR,
                B_MEM_RD | B_DR_LD, alu(ALU_LOAD), B_AR_LD};
        bus.ir = 16'h2010;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) cyc();
            n_total++;
            if (w_obs !== exp[i]) $display("FAIL lda_c%0d obs=%h exp=%h", i, w_obs, exp[i]);
            else n_pass++;
        end
    endtask

    task automatic test_isz();
        logic [20:0] exp_i [8];
        logic [20:0] exp_d [7];
        exp_i = '{B_AR_LD, B_MEM_RD | B_IR_LD | B_PC_INC, B_AR_LD | B_SEL_IR,
                  B_MEM_RD | B_AR_LD | B_SEL_MEM, B_MEM_RD | B_DR_LD, B_DR_INC,
                  B_MEM_WR | B_WSEL_DR | B_PC_INC, B_AR_LD};
        bus.ir = 16'hE010;
        bus.dr_zero = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) cyc();
            n_total++;
            if (w_obs !== exp_i[i]) $display("FAIL isz_ind_c%0d obs=%h exp=%h", i, w_obs, exp_i[i]);
            else n_pass++;
        end
        exp_d = '{B_AR_LD, B_MEM_RD | B_IR_LD | B_PC_INC, B_AR_LD | B_SEL_IR,
                  B_MEM_RD | B_DR_LD, B_DR_INC, B_MEM_WR | B_WSEL_DR, B_AR_LD};
        bus.ir = 16'h6010;
        bus.dr_zero = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) cyc();
            n_total++;
            if (w_obs !== exp_d[i]) $display("FAIL isz_dir_c%0d obs=%h exp=%h", i, w_obs, exp_d[i]);
            else n_pass++;
        end
    endtask

    task automatic test_mri();
        logic [15:0] t_ir  [5];
        logic [20:0] t_e1  [5];
        logic [20:0] t_e2  [5];
        bit          t_lng [5];
        t_ir  = '{16'h0010, 16'h1010, 16'h3010, 16'h4010, 16'h5010};
        t_e1  = '{B_MEM_RD | B_DR_LD, B_MEM_RD | B_DR_LD, B_MEM_WR, B_PC_LD,
                  B_MEM_WR | B_WSEL_PC | B_PC_LD};
        t_e2  = '{alu(ALU_AND), alu(ALU_ADD), B_AR_LD, B_AR_LD, B_PC_INC};
        t_lng = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            bus.ir = t_ir[i];
            repeat (3) cyc();
            n_total++;
            if (w_obs !== t_e1[i]) $display("FAIL mri_%h_e1 obs=%h exp=%h", t_ir[i], w_obs, t_e1[i]);
            else n_pass++;
            cyc();
            n_total++;
            if (w_obs !== t_e2[i]) $display("FAIL mri_%h_e2 obs=%h exp=%h", t_ir[i], w_obs, t_e2[i]);
            else n_pass++;
            if (t_lng[i]) begin
                cyc();
                n_total++;
                if (w_obs !== B_AR_LD) $display("FAIL mri_%h_done obs=%h exp=%h", t_ir[i], w_obs, B_AR_LD);
                else n_pass++;
            end
        end
    endtask

    task automatic test_rr();
        logic [15:0] t_ir [11];
        logic        t_az [11];
        logic        t_fi [11];
        logic [20:0] t_ex [11];
        t_ir = '{16'h7340, 16'h7A00, 16'h7004, 16'h7004, 16'h7000, 16'hF800,
                 16'hF400, 16'hF200, 16'hF200, 16'hF03F, 16'h7020};
        t_az = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        t_fi = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        t_ex = '{alu(ALU_CMA), alu(ALU_CLA), B_PC_INC, B_NONE, B_NONE,
                 alu(ALU_INPR) | B_FGI_CLR, B_OUT_LD | B_FGO_CLR, B_PC_INC, B_NONE,
                 B_NONE, alu(ALU_INC)};
        for (int i = 0; i < 11; i++) begin
            bus.ir = t_ir[i];
            bus.ac_zero = t_az[i];
            bus.fgi = t_fi[i];
            repeat (3) cyc();
            n_total++;
            if (w_obs !== t_ex[i]) $display("FAIL rr_%0d_%h obs=%h exp=%h", i, t_ir[i], w_obs, t_ex[i]);
            else n_pass++;
            cyc();
            n_total++;
            if (w_obs !== B_AR_LD) $display("FAIL rr_%0d_done obs=%h exp=%h", i, w_obs, B_AR_LD);
            else n_pass++;
        end
        bus.ac_zero = 1'b0;
        bus.fgi = 1'b0;
    endtask

    task automatic test_halt();
        bus.ir = 16'h7001;
        repeat (3) cyc();
        n_total++;
        if (w_obs !== B_NONE || bus.halted !== 1'b0)
            $display("FAIL hlt_exec1 obs=%h halted=%b exp=%h/0", w_obs, bus.halted, B_NONE);
        else n_pass++;
        for (int i = 0; i < 10; i++) begin
            cyc();
            n_total++;
            if (w_obs !== B_NONE || bus.halted !== 1'b1)
                $display("FAIL hlt_hold_%0d obs=%h halted=%b exp=%h/1", i, w_obs, bus.halted, B_NONE);
            else n_pass++;
        end
        bus.run = 1'b1;
        cyc();
        bus.run = 1'b0;
        n_total++;
        if (w_obs !== B_AR_LD || bus.halted !== 1'b0)
            $display("FAIL hlt_resume obs=%h halted=%b exp=%h/0", w_obs, bus.halted, B_AR_LD);
        else n_pass++;
    endtask

    task automatic test_interrupt();
        logic [20:0] exp_int [4];
        exp_int = '{B_AR_LD | B_SEL_ZERO, B_MEM_WR | B_WSEL_PC | B_PC_CLR, B_PC_INC, B_AR_LD};
        bus.ir = 16'hF080;
        repeat (4) cyc();
        n_total++;
        if (bus.ien !== 1'b1 || w_obs !== B_AR_LD)
            $display("FAIL ion_set ien=%b obs=%h exp=1/%h", bus.ien, w_obs, B_AR_LD);
        else n_pass++;

        bus.ir = 16'h7001;
        repeat (4) cyc();
        bus.fgi = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_total++;
            if (bus.halted !== 1'b1 || bus.ien !== 1'b1 || w_obs !== B_NONE)
                $display("FAIL halt_ignores_int_%0d halted=%b ien=%b obs=%h exp=1/1/0",
                         i, bus.halted, bus.ien, w_obs);
            else n_pass++;
        end
        bus.run = 1'b1;
        cyc();
        bus.run = 1'b0;
        n_total++;
        if (w_obs !== B_AR_LD) $display("FAIL halt_to_fetch obs=%h exp=%h", w_obs, B_AR_LD);
        else n_pass++;

        bus.ir = 16'h7000;
        repeat (3) cyc();
        for (int i = 0; i < 4; i++) begin
            cyc();
            n_total++;
            if (w_obs !== exp_int[i]) $display("FAIL int_c%0d obs=%h exp=%h", i, w_obs, exp_int[i]);
            else n_pass++;
            if (i == 2) begin
                n_total++;
                if (bus.ien !== 1'b1) $display("FAIL int2_ien ien=%b exp=1", bus.ien);
                else n_pass++;
            end
        end
        n_total++;
        if (bus.ien !== 1'b0) $display("FAIL int_ien_clr ien=%b exp=0", bus.ien);
        else n_pass++;

        bus.fgi = 1'b0;
        bus.ir = 16'hF080;
        repeat (3) cyc();
        bus.fgi = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            n_total++;
            if (w_obs !== exp_int[i]) $display("FAIL ion_flag_c%0d obs=%h exp=%h", i, w_obs, exp_int[i]);
            else n_pass++;
        end
        n_total++;
        if (bus.ien !== 1'b0) $display("FAIL ion_flag_ien ien=%b exp=0", bus.ien);
        else n_pass++;
        bus.fgi = 1'b0;
    endtask

    task automatic test_reset_mid();
        bus.ir = 16'hF080;
        repeat (4) cyc();
        bus.ir = 16'h6010;
        repeat (4) cyc();
        n_total++;
        if (w_obs !== B_DR_INC || bus.ien !== 1'b1)
            $display("FAIL mid_pre obs=%h ien=%b exp=%h/1", w_obs, bus.ien, B_DR_INC);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++;
        if (w_obs !== B_NONE || bus.ien !== 1'b0)
            $display("FAIL mid_reset obs=%h ien=%b exp=%h/0", w_obs, bus.ien, B_NONE);
        else n_pass++;
        repeat (2) cyc();
        rst_n = 1'b1;
        #1;
        n_total++;
        if (w_obs !== B_AR_LD) $display("FAIL mid_release obs=%h exp=%h", w_obs, B_AR_LD);
        else n_pass++;
        cyc();
        n_total++;
        if (w_obs !== (B_MEM_RD | B_IR_LD | B_PC_INC))
            $display("FAIL mid_fetch1 obs=%h exp=%h", w_obs, B_MEM_RD | B_IR_LD | B_PC_INC);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_lda();
        test_isz();
        test_mri();
        test_rr();
        test_halt();
        test_interrupt();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout passed=%0d total=%0d", n_pass, n_total);
        $fatal(1, "timeout");
    end

endmodule
